rr_arbiter_enc: RTL and testbench

Round-robin arbiter sharing one downstream resource among 16 requesters. Sits in front of the shared resource: samples a 16-bit request vector, issues a registered one-hot grant plus its 4-bit binary index, and holds the grant until the owner signals completion. Rotating priority guarantees that every asserted requester is served within 16 grants.

---
 rtl/rr_arbiter_enc.sv | 82 ++++++++
 tb/tb_rr_arbiter_enc.sv | 103 ++++++++++
 2 files changed

// File: rtl/rr_arbiter_enc.sv
// rr_arbiter_enc: 16-way round-robin arbiter with one-hot and binary grant; ARB_TIMEOUT_EN adds a grant watchdog
module rr_arbiter_enc #(
  parameter int NUM_REQ     = 16,
  parameter int IDX_W       = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [IDX_W-1:0] ptr, sel, c;
  logic hit, take, rel, wd;
  // first requester after ptr, wrapping; lowest offset wins because it is written last
  always_comb begin
    sel = '0;
    hit = 1'b0;
    c = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      c = ptr + IDX_W'(k);
      if (req[c]) begin
        sel = c;
        hit = 1'b1;
      end
    end
  end
  // next state: grant from idle, release on done, withdrawal or watchdog
  always_comb begin
    state_n = state;
    take = (state == IDLE) && en && hit;
    rel = (state == GRANT) && (done || !req[gnt_idx] || wd);
    if (take) state_n = GRANT;
    if (rel) state_n = IDLE;
  end
  // state, pointer and registered grant outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '1;
      gnt <= '0;
      gnt_idx <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state <= state_n;
      if (take) begin
        gnt <= NUM_REQ'(1) << sel;
        gnt_idx <= sel;
        gnt_valid <= 1'b1;
      end else if (rel) begin
        gnt <= '0;
        gnt_idx <= '0;
        gnt_valid <= 1'b0;
        ptr <= gnt_idx;
      end
    end
  end
`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt;
  assign wd = (cnt == 8'(TIMEOUT_CYC - 1)) && !done;
  // watchdog counter; timeout pulses the cycle after a forced release
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= (state == GRANT) && wd;
      if (take) cnt <= '0;
      else if (state == GRANT && !rel) cnt <= cnt + 8'd1;
    end
  end
`else
  assign wd = 1'b0;
  assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_rr_arbiter_enc.sv
// tb_rr_arbiter_enc: scoreboard bench for rr_arbiter_enc
module tb_rr_arbiter_enc;
`ifdef ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif
  logic clk = 1'b0;
  logic rst_n, en, done;
  logic [15:0] req, gnt;
  logic [3:0] gnt_idx;
  logic gnt_valid, timeout;
  int n_tests = 0;
  int n_fail = 0;
  typedef struct {
    string tag;
    logic [15:0] g;
    logic t;
  } exp_t;
  exp_t q[$];
  rr_arbiter_enc #(.NUM_REQ(16), .IDX_W(4), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );
  always #5 clk = ~clk;
  function automatic logic [3:0] idx_of(input logic [15:0] g);
    logic [3:0] r = '0;
    for (int i = 0; i < 16; i++) if (g[i]) r = 4'(i);
    return r;
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic r_n, input logic e, input logic [15:0] r,
                     input logic d, input logic [15:0] eg, input logic et);
    exp_t x;
    rst_n = r_n;
    en = e;
    req = r;
    done = d;
    q.push_back('{tag, eg, et});
    @(posedge clk);
    #1;
    x = q.pop_front();
    check({x.tag, ".gnt"}, 32'(gnt), 32'(x.g));
    check({x.tag, ".idx"}, 32'(gnt_idx), 32'(idx_of(x.g)));
    check({x.tag, ".valid"}, 32'(gnt_valid), 32'(x.g != 0));
    check({x.tag, ".timeout"}, 32'(timeout), 32'(x.t));
  endtask
  initial begin
    cyc("rst0", 0, 0, 16'h0000, 0, 16'h0000, 0);
    cyc("rst1", 0, 1, 16'h0005, 0, 16'h0000, 0);
    cyc("g0", 1, 1, 16'h0005, 0, 16'h0001, 0);
    cyc("rel0", 1, 1, 16'h0005, 1, 16'h0000, 0);
    cyc("g2", 1, 1, 16'h0005, 0, 16'h0004, 0);
    cyc("rel2", 1, 1, 16'h0005, 1, 16'h0000, 0);
    cyc("rst2", 0, 1, 16'hFFFF, 0, 16'h0000, 0);
    for (int i = 0; i <= 16; i++) begin
      cyc($sformatf("rot%0d", i), 1, 1, 16'hFFFF, 0, 16'(1) << (i % 16), 0);
      cyc($sformatf("hold%0d", i), 1, 1, 16'hFFFF, 0, 16'(1) << (i % 16), 0);
      cyc($sformatf("rrel%0d", i), 1, 1, 16'hFFFF, 1, 16'h0000, 0);
    end
    cyc("g14", 1, 1, 16'h4000, 0, 16'h4000, 0);
    cyc("rel14", 1, 1, 16'h4000, 1, 16'h0000, 0);
    cyc("wrap15", 1, 1, 16'h8001, 0, 16'h8000, 0);
    cyc("rel15", 1, 1, 16'h8001, 1, 16'h0000, 0);
    cyc("wrap0", 1, 1, 16'h8001, 0, 16'h0001, 0);
    cyc("relw0", 1, 1, 16'h8001, 1, 16'h0000, 0);
    cyc("en_off0", 1, 0, 16'h0100, 0, 16'h0000, 0);
    cyc("en_off1", 1, 0, 16'h0100, 0, 16'h0000, 0);
    cyc("g8", 1, 1, 16'h0100, 0, 16'h0100, 0);
    cyc("en_drop0", 1, 0, 16'h0100, 0, 16'h0100, 0);
    cyc("en_drop1", 1, 0, 16'h0100, 0, 16'h0100, 0);
    cyc("rel8", 1, 0, 16'h0100, 1, 16'h0000, 0);
    cyc("regrant8", 1, 1, 16'h0100, 0, 16'h0100, 0);
    cyc("withdraw", 1, 1, 16'h0000, 0, 16'h0000, 0);
    cyc("g8b", 1, 1, 16'h0100, 0, 16'h0100, 0);
    cyc("both_rel", 1, 1, 16'h0000, 1, 16'h0000, 0);
    cyc("idle_done", 1, 1, 16'h0000, 1, 16'h0000, 0);
    cyc("idle_done_req", 1, 1, 16'h0200, 1, 16'h0200, 0);
    cyc("rel9", 1, 1, 16'h0200, 1, 16'h0000, 0);
    cyc("g6", 1, 1, 16'h0040, 0, 16'h0040, 0);
    cyc("mid_rst", 0, 1, 16'h0041, 1, 16'h0000, 0);
    cyc("post_rst", 1, 1, 16'h0041, 0, 16'h0001, 0);
    cyc("relpr", 1, 1, 16'h0041, 1, 16'h0000, 0);
    cyc("to_g", 1, 1, 16'h0002, 0, 16'h0002, 0);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < TO - 1; i++) cyc($sformatf("to_hold%0d", i), 1, 1, 16'h0002, 0, 16'h0002, 0);
    cyc("to_fire", 1, 1, 16'h0002, 0, 16'h0000, 1);
    cyc("to_regrant", 1, 1, 16'h0002, 0, 16'h0002, 0);
`else
    for (int i = 0; i < 8; i++) cyc($sformatf("to_hold%0d", i), 1, 1, 16'h0002, 0, 16'h0002, 0);
`endif
    cyc("to_rel", 1, 1, 16'h0002, 1, 16'h0000, 0);
    cyc("end_idle", 1, 0, 16'h0000, 0, 16'h0000, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
